load_store_unit: RTL

//   Initiator side of the data-memory interface: accepts one load/store request from the execute stage and drives
//   mem_read/mem_write/address/write_data of the 64-bit word-addressed data memory.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, RV64 lane extract/extend on loads,
// read-modify-write for sub-dword stores, single registered response per request.
module load_store_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter bit          DEBUG  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_write_data,
    input  logic [63:0]       mem_read_data
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        off_q, off_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [63:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;

    logic        req_misaligned, req_illegal;
    logic [5:0]  lane_shift;
    logic [63:0] rd_shifted, load_data, lane_mask, merged;

    // Tracing is left to the surrounding environment; the flag only selects that behaviour.
    if (DEBUG) begin : g_debug
    end

    always_comb begin
        unique case (req_funct3[1:0])
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = |req_addr[2:0];
        endcase
        req_illegal = req_is_store ? req_funct3[2] : (req_funct3 == 3'd7);
    end

    always_comb begin
        lane_shift = {off_q, 3'b000};
        rd_shifted = mem_read_data >> lane_shift;
        unique case (funct3_q)
            3'd0:    load_data = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
            3'd1:    load_data = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            3'd2:    load_data = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            3'd3:    load_data = rd_shifted;
            3'd4:    load_data = {56'd0, rd_shifted[7:0]};
            3'd5:    load_data = {48'd0, rd_shifted[15:0]};
            3'd6:    load_data = {32'd0, rd_shifted[31:0]};
            default: load_data = 64'd0;
        endcase
        unique case (funct3_q[1:0])
            2'd0:    lane_mask = 64'h0000_0000_0000_00ff;
            2'd1:    lane_mask = 64'h0000_0000_0000_ffff;
            2'd2:    lane_mask = 64'h0000_0000_ffff_ffff;
            default: lane_mask = '1;
        endcase
        lane_mask = lane_mask << lane_shift;
        merged    = (mem_read_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
    end

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    funct3_d      = req_funct3;
                    off_d         = req_addr[2:0];
                    wdata_d       = req_wdata;
                    mem_address_d = {req_addr[ADDR_W-1:3], 3'b000};
                    if (req_misaligned || req_illegal) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'd0;
                    end else if (!req_is_store) begin
                        state_d    = StLoad;
                        mem_read_d = 1'b1;
                    end else if (req_funct3 == 3'd3) begin
                        state_d     = StWrite;
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = StRmwRd;
                        mem_read_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = load_data;
            end
            StRmwRd: begin
                state_d     = StWrite;
                mem_write_d = 1'b1;
                mem_wdata_d = merged;
            end
            StWrite: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 64'd0;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 64'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            funct3_q      <= 3'd0;
            off_q         <= 3'd0;
            wdata_q       <= 64'd0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 64'd0;
            resp_err_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= 64'd0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready      = (state_q == StIdle);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_wdata_q;

endmodule
